// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct constants and loader descriptor types shared by the encoder and the control unit.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  // Codes 6 and 7 are deliberately unnamed: they are the illegal classes.
  typedef enum logic [2:0] {
    CLS_LW    = 3'd0,
    CLS_SW    = 3'd1,
    CLS_RTYPE = 3'd2,
    CLS_ADDI  = 3'd3,
    CLS_BEQ   = 3'd4,
    CLS_J     = 3'd5
  } op_class_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLT = 2'd2,
    ALU_MUL = 2'd3
  } alu_fn_e;

  typedef struct packed {
    op_class_e   op_class;
    logic [1:0]  alu_fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } desc_t;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational descriptor-to-machine-word packer; zero latency, no flow control.
// Irrelevant fields for a class are ignored; classes 6/7 raise illegal and yield a zero word.
module instr_field_packer
  import mips_isa_pkg::*;
(
  input  desc_t       desc,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] funct;

  always_comb begin
    funct = FN_ADD;
    case (alu_fn_e'(desc.alu_fn))
      ALU_ADD: funct = FN_ADD;
      ALU_SUB: funct = FN_SUB;
      ALU_SLT: funct = FN_SLT;
      ALU_MUL: funct = FN_MUL;
      default: funct = FN_ADD;
    endcase
  end

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (desc.op_class)
      CLS_LW:    word = i_type(OP_LW,   desc.rs, desc.rt, desc.imm);
      CLS_SW:    word = i_type(OP_SW,   desc.rs, desc.rt, desc.imm);
      CLS_ADDI:  word = i_type(OP_ADDI, desc.rs, desc.rt, desc.imm);
      CLS_BEQ:   word = i_type(OP_BEQ,  desc.rs, desc.rt, desc.imm);
      CLS_J:     word = {OP_J, desc.target};
      CLS_RTYPE: word = {OP_RTYPE, desc.rs, desc.rt, desc.rd, 5'd0, funct};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded MIPS words into IMEM; word written the cycle after its accept, 1 word/cycle.
// in_ready drops when DEPTH words are committed or the session's last descriptor was taken.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        op_class,
  input  logic [1:0]        alu_fn,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_M1 = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

  state_e          state, state_nxt;
  desc_t           desc;
  logic [31:0]     word;
  logic            illegal;
  logic            xfer;
  logic            restart;
  logic            full;
  logic [ADDR_W:0] committed;

  assign desc = '{op_class: op_class_e'(op_class), alu_fn: alu_fn, rs: rs, rt: rt,
                  rd: rd, imm: imm, target: target};

  instr_field_packer u_packer (
    .desc    (desc),
    .word    (word),
    .illegal (illegal)
  );

  // The word in flight on the write port counts against DEPTH before word_count catches up.
  assign committed = word_count + {{ADDR_W{1'b0}}, imem_we};
  assign xfer      = in_valid & in_ready;
  assign full      = (state == S_LOAD) && (word_count == DEPTH_C);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    restart   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_LOAD;
          restart   = 1'b1;
        end
      end
      S_LOAD: begin
        in_ready = (committed < DEPTH_C);
        if (in_valid && in_ready && in_last) state_nxt = illegal ? S_DONE : S_FLUSH;
        else if (full)                       state_nxt = S_DONE;
      end
      S_FLUSH: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_we      <= 1'b0;
      imem_wdata   <= '0;
      imem_addr    <= BASE_C;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= xfer && !illegal;
      if (xfer && !illegal) imem_wdata <= word;
      if (restart) begin
        imem_addr    <= BASE_C;
        word_count   <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (imem_we) begin
          word_count <= word_count + CNT_ONE;
          // Hold the address on the final slot so it never wraps past the memory.
          if (word_count < DEPTH_M1) imem_addr <= imem_addr + ADDR_ONE;
        end
        if (xfer && illegal) err_illegal  <= 1'b1;
        if (full)            err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed plus randomized sessions against a descriptor-list model of the loader.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_ready, in_last;
  logic [2:0]        op_class;
  logic [1:0]        alu_fn;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              done, err_illegal, err_overflow;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op_class(op_class), .alu_fn(alu_fn), .rs(rs), .rt(rt), .rd(rd),
    .imm(imm), .target(target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .done(done),
    .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int fn; int rs; int rt; int rd; int imm; int target; bit last;
  } desc_s;
  typedef struct {
    int addr; logic [31:0] data; int cyc;
  } wr_s;

  desc_s       sess[$];
  wr_s         wlog[$];
  logic [31:0] exp_q[$];
  bit          exp_ill, exp_ovf, exp_legal_last;
  int          cyc = 0;
  int          xfer_cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          rand_start = 0;
  bit          use_gaps = 0;
  int          opc_tab[6] = '{35, 43, 0, 8, 4, 2};
  int          fn_tab[4]  = '{32, 34, 42, 28};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_s w;
    if (imem_we === 1'b1) begin
      w.addr = int'(imem_addr);
      w.data = imem_wdata;
      w.cyc  = cyc;
      wlog.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic desc_s mk(int op, int fn, int rs_v, int rt_v, int rd_v, int imm_v,
                               int tgt, bit last);
    desc_s d;
    d.op = op; d.fn = fn; d.rs = rs_v; d.rt = rt_v; d.rd = rd_v;
    d.imm = imm_v; d.target = tgt; d.last = last;
    return d;
  endfunction

  // Arithmetic field placement: opcode*2^26 + rs*2^21 + rt*2^16 + ...
  function automatic logic [31:0] ref_word(desc_s d);
    longint w;
    w = longint'(opc_tab[d.op]) * 64'd67108864;
    if (d.op == 5) w += longint'(d.target);
    else begin
      w += longint'(d.rs) * 2097152 + longint'(d.rt) * 65536;
      if (d.op == 2) w += longint'(d.rd) * 2048 + longint'(fn_tab[d.fn]);
      else           w += longint'(d.imm);
    end
    return w[31:0];
  endfunction

  function automatic void run_model();
    int n;
    bit ended;
    n = 0; ended = 0;
    exp_q.delete(); exp_ill = 0; exp_ovf = 0; exp_legal_last = 0;
    foreach (sess[i]) begin
      if (n == DEPTH) break;
      if (sess[i].op > 5) begin
        exp_ill = 1;
        if (sess[i].last) begin ended = 1; break; end
        continue;
      end
      exp_q.push_back(ref_word(sess[i]));
      n++;
      if (sess[i].last) begin ended = 1; exp_legal_last = 1; break; end
    end
    if (!ended && n == DEPTH) exp_ovf = 1;
  endfunction

  task automatic drive(desc_s d);
    in_valid = 1'b1; in_last = d.last;
    op_class = 3'(d.op); alu_fn = 2'(d.fn);
    rs = 5'(d.rs); rt = 5'(d.rt); rd = 5'(d.rd);
    imm = 16'(d.imm); target = 26'(d.target);
  endtask

  task automatic send(input desc_s d, output bit ok);
    ok = 0;
    drive(d);
    for (int k = 0; k < 8; k++) begin
      start = (rand_start && in_ready === 1'b1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (in_ready === 1'b1) begin
        ok = 1;
        xfer_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic run_session(input string tag);
    bit ok, got_done;
    int done_cyc;
    run_model();
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (sess[i]) begin
      send(sess[i], ok);
      if (!ok || sess[i].last) break;
      if (use_gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    got_done = 0; done_cyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin got_done = 1; done_cyc = cyc; break; end
      @(negedge clk);
    end
    chk({tag, ".done_seen"}, 64'(got_done), 64'd1);
    repeat (2) @(negedge clk);
    chk({tag, ".nwrites"}, 64'(wlog.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < wlog.size()) begin
        chk($sformatf("%s.addr%0d", tag, i), 64'(wlog[i].addr), 64'(BASE + i));
        chk($sformatf("%s.data%0d", tag, i), 64'(wlog[i].data), 64'(exp_q[i]));
      end
    end
    chk({tag, ".word_count"}, 64'(word_count), 64'(exp_q.size()));
    chk({tag, ".err_illegal"}, 64'(err_illegal), 64'(exp_ill));
    chk({tag, ".err_overflow"}, 64'(err_overflow), 64'(exp_ovf));
    chk({tag, ".in_ready_end"}, 64'(in_ready), 64'd0);
    chk({tag, ".done_held"}, 64'(done), 64'd1);
    if (exp_legal_last && wlog.size() > 0) begin
      chk({tag, ".lat_write"}, 64'(wlog[$].cyc - xfer_cyc), 64'd1);
      chk({tag, ".lat_done"}, 64'(done_cyc - xfer_cyc), 64'd2);
    end
    if (!exp_ill && !use_gaps && wlog.size() > 1)
      chk({tag, ".back_to_back"}, 64'(wlog[$].cyc - wlog[0].cyc), 64'(wlog.size() - 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, ".imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, ".imem_addr"}, 64'(imem_addr), 64'(BASE));
    chk({tag, ".imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, ".word_count"}, 64'(word_count), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".err_illegal"}, 64'(err_illegal), 64'd0);
    chk({tag, ".err_overflow"}, 64'(err_overflow), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len;
    rst_n = 1'b0; start = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single LW, expected 0x8C450010
    sess.delete();
    sess.push_back(mk(0, 0, 2, 5, 9, 16'h0010, 0, 1));
    run_session("lw_single");
    chk("lw_single.literal", 64'(exp_q[0]), 64'h8C450010);

    // 2: back-to-back RTYPE add/sub/slt/mul, last on mul (fills DEPTH exactly)
    sess.delete();
    for (int f = 0; f < 4; f++) sess.push_back(mk(2, f, 1, 2, 3, 0, 0, f == 3));
    run_session("rtype4");

    // 3: BEQ with negative offset, then J
    sess.delete();
    sess.push_back(mk(4, 0, 1, 2, 0, 16'hFFFF, 0, 0));
    sess.push_back(mk(5, 0, 0, 0, 0, 0, 26'h0000004, 1));
    run_session("beq_j");

    // 4: illegal class between two ADDIs
    sess.delete();
    sess.push_back(mk(3, 0, 4, 5, 0, 16'h1234, 0, 0));
    sess.push_back(mk(7, 0, 1, 1, 1, 16'hAAAA, 0, 0));
    sess.push_back(mk(3, 0, 6, 7, 0, 16'h8001, 0, 1));
    run_session("addi_ill");

    // 5: six descriptors, no last: overflow at DEPTH
    sess.delete();
    for (int i = 0; i < 6; i++) sess.push_back(mk(i % 2, 0, i, i + 1, 0, 16'h100 + i, 0, 0));
    run_session("overflow");

    // 6: reset mid-stream after two words
    sess.delete();
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send(mk(3, 0, 1, 2, 0, 16'h0001, 0, 0), ok);
    send(mk(3, 0, 1, 2, 0, 16'h0002, 0, 0), ok);
    drive(mk(3, 0, 1, 2, 0, 16'h0003, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.writes_before", 64'(wlog.size()), 64'd2);
    repeat (4) @(negedge clk);
    chk("midrst.writes_after", 64'(wlog.size()), 64'd2);
    check_idle_outputs("midrst");
    in_valid = 1'b0;
    sess.push_back(mk(1, 0, 3, 4, 0, 16'h0008, 0, 1));
    run_session("after_rst");

    // Randomized sessions with spurious start pulses during LOAD
    rand_start = 1;
    for (int s = 0; s < 16; s++) begin
      sess.delete();
      use_gaps = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) != 0) begin
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++)
          sess.push_back(mk(($urandom_range(0, 9) < 8) ? $urandom_range(0, 5) : $urandom_range(6, 7),
                            $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 65535),
                            $urandom_range(0, 26'h3FFFFFF), i == len - 1));
      end else begin
        len = DEPTH + $urandom_range(1, 2);
        for (int i = 0; i < len; i++)
          sess.push_back(mk($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 31),
                            $urandom_range(0, 31), $urandom_range(0, 31),
                            $urandom_range(0, 65535), $urandom_range(0, 26'h3FFFFFF), 0));
      end
      run_session($sformatf("rand%0d", s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encodes symbolic instruction descriptors into 32-bit MIPS machine words and writes them sequentially into the instruction memory. Its opcode and funct encodings must be accepted by the processor's control unit. It sits between a testbench or host loader port and the IMEM write port, and is used to fill program memory before the core runs. Input uses a valid/ready handshake; output is a single-cycle write strobe.

Parameters:
ADDR_W, 6, word-address width of IMEM.
DEPTH, 64, number of IMEM words; must be at most 2**ADDR_W.
BASE_ADDR, 0, first word address written after start.

Ports:
clk  input  1  system clock, all state updates on its rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  single-cycle pulse; begins a load session from IDLE or DONE.
in_valid  input  1  descriptor valid.
in_ready  output  1  block can accept a descriptor this cycle.
in_last  input  1  marks the final descriptor of the session.
op_class  input  3  0=LW, 1=SW, 2=RTYPE, 3=ADDI, 4=BEQ, 5=J; 6 and 7 are illegal.
alu_fn  input  2  RTYPE only: 0=add, 1=sub, 2=slt, 3=mul.
rs  input  5  source register.
rt  input  5  target register.
rd  input  5  destination register (RTYPE).
imm  input  16  immediate or branch offset.
target  input  26  jump target field.
imem_we  output  1  write strobe, one cycle per word.
imem_addr  output  ADDR_W  word address.
imem_wdata  output  32  encoded instruction.
word_count  output  ADDR_W+1  number of words written this session.
done  output  1  session complete; held high until the next start.
err_illegal  output  1  sticky; an illegal op_class was consumed.
err_overflow  output  1  sticky; DEPTH was reached before in_last.

Behaviour:
- Reset is synchronous on rst_n=0. All outputs are driven to 0, state goes to IDLE, and the address counter loads BASE_ADDR. Reset mid-session abandons it; no further writes occur.
- States:
  - IDLE: on start go to LOAD; clear word_count and both err flags; address loads BASE_ADDR.
  - LOAD: in_ready = 1 while word_count < DEPTH and no terminating descriptor is pending.
  - FLUSH: finishes the final write.
  - DONE: done = 1; start returns to LOAD with counters and flags cleared.
- start received in LOAD or FLUSH is ignored.
- A transfer occurs when in_valid and in_ready are both 1 (in the LOAD state).
- Latency:
  - The encoded word is registered on the transfer edge.
  - imem_we = 1 for exactly the following cycle, with imem_addr = current address and imem_wdata = encoded word.
  - The address and word_count increment at the end of that write cycle.
  - Throughput is 1 word per cycle.
- Encoding, fields listed MSB first:
  - LW: 100011 | rs | rt | imm.
  - SW: 101011 | rs | rt | imm.
  - ADDI: 001000 | rs | rt | imm.
  - BEQ: 000100 | rs | rt | imm.
  - J: 000010 | target.
  - RTYPE: 000000 | rs | rt | rd | 00000 | funct, with funct add=100000, sub=100010, slt=101010, mul=011100.
- Illegal op_class:
  - The descriptor is consumed, but there is no write and no address increment.
  - err_illegal is set.
  - If in_last is also set, go to DONE on the next cycle.
- in_last on a legal descriptor: in_ready drops in the next cycle, state goes to FLUSH, and the write completes. done rises the cycle after the write.
- Full condition: word_count reaches DEPTH with no in_last seen.
  - in_ready stays 0.
  - err_overflow is set and state goes to DONE.
  - Held descriptors are never written, and the address never wraps.
- A transfer and its pending write may overlap in the same cycle (pipelined). The write of word N and the acceptance of word N+1 coincide.
- Fields irrelevant to an op_class are ignored; for example, rd is ignored for LW.

Decomposition:
- Shared package mips_isa_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J);
  - funct constants (FN_ADD, FN_SUB, FN_SLT, FN_MUL);
  - op_class encodings.
- The control unit must reuse the same constants.
- One combinational sub-module, instr_field_packer, maps the descriptor to a 32-bit word plus an illegal flag. The top level holds the FSM, counters and output registers.

Test Plan:
1. Reset, then start, then a single LW with rs=2, rt=5, imm=0x0010 and in_last=1 -> one cycle with imem_we=1, imem_addr=0, imem_wdata=0x8C450010; done=1 two cycles after the transfer; word_count=1.
2. Back-to-back RTYPE add (rs=1, rt=2, rd=3), sub, slt and mul with in_valid held high, last on mul -> four consecutive writes at addr 0..3 with data 0x00221820, 0x00221822, 0x0022182A and 0x0022181C.
3. BEQ (rs=1, rt=2, imm=0xFFFF) followed by J (target=0x0000004, last) -> 0x1022FFFF at addr 0 and 0x08000004 at addr 1.
4. op_class=7 between two ADDI instructions -> ADDI words at addr 0 and 1 with no gap in addresses; err_illegal=1; word_count=2.
5. DEPTH=4, with 6 descriptors offered and no last -> exactly 4 writes; in_ready=0 afterwards; err_overflow=1; done=1; imem_addr never exceeds 3.
6. rst_n=0 for one cycle mid-stream, after 2 words -> no imem_we afterwards; all outputs 0; a new start writes again from addr 0.
